// File: rtl/signal_safety_monitor.sv
// Safety stage behind the traffic-light controller: registered lamp decode,
// green-conflict and illegal-transition detection, flash fault mode and all-red recovery.
module signal_safety_monitor #(
  parameter int CONFLICT_CYCLES = 1,
  parameter int FLASH_HALF      = 5,
  parameter int ALLRED_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fault_clr,
  input  logic [1:0] Highway_1,
  input  logic [1:0] Highway_2,
  input  logic [1:0] Farm_1,
  input  logic [1:0] Farm_2,
  output logic [2:0] hw1_lamp,
  output logic [2:0] hw2_lamp,
  output logic [2:0] fm1_lamp,
  output logic [2:0] fm2_lamp,
  output logic [1:0] mode,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    FLASH   = 2'b01,
    ALL_RED = 2'b10
  } mode_t;

  localparam logic [1:0] GREEN      = 2'b00;
  localparam logic [1:0] YELLOW     = 2'b01;
  localparam logic [1:0] RED        = 2'b10;
  localparam logic [1:0] RED_YELLOW = 2'b11;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  localparam int CW = $clog2(CONFLICT_CYCLES + 2);
  localparam int FW = $clog2(2 * FLASH_HALF + 1);
  localparam int AW = $clog2(ALLRED_CYCLES + 1);

  localparam logic [CW-1:0] CONF_MAX   = CW'(CONFLICT_CYCLES);
  localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);
  localparam logic [FW-1:0] FLASH_ON   = FW'(FLASH_HALF);
  localparam logic [AW-1:0] ALLRED_END = AW'(ALLRED_CYCLES - 1);

  mode_t         state;
  logic [CW-1:0] conf_cnt;
  logic [FW-1:0] flash_cnt;
  logic [FW-1:0] flash_next;
  logic [AW-1:0] allred_cnt;
  logic [1:0]    prev_hw1, prev_hw2, prev_fm1, prev_fm2;

  logic conflict;
  logic conf_viol;
  logic trans_viol;
  logic violation;

  function automatic logic [2:0] decode(input logic [1:0] c);
    case (c)
      GREEN:   decode = 3'b001;
      YELLOW:  decode = 3'b010;
      RED:     decode = 3'b100;
      default: decode = 3'b110;
    endcase
  endfunction

  // Any change into Red is always safe; otherwise only the normal cycle order is allowed.
  function automatic logic illegal(input logic [1:0] prev, input logic [1:0] cur);
    logic legal;
    legal = (prev == cur) || (cur == RED) ||
            (prev == RED        && cur == RED_YELLOW) ||
            (prev == RED_YELLOW && cur == GREEN) ||
            (prev == GREEN      && cur == YELLOW);
    illegal = !legal;
  endfunction

  always_comb begin
    conflict   = ((Highway_1 != RED) || (Highway_2 != RED)) &&
                 ((Farm_1 != RED) || (Farm_2 != RED));
    conf_viol  = conflict && (conf_cnt == CONF_MAX);
    trans_viol = illegal(prev_hw1, Highway_1) || illegal(prev_hw2, Highway_2) ||
                 illegal(prev_fm1, Farm_1)    || illegal(prev_fm2, Farm_2);
    violation  = conf_viol || trans_viol;
    flash_next = (flash_cnt == FLASH_LAST) ? '0 : flash_cnt + 1'b1;
  end

  assign mode = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NORMAL;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      hw1_lamp   <= LAMP_RED;
      hw2_lamp   <= LAMP_RED;
      fm1_lamp   <= LAMP_RED;
      fm2_lamp   <= LAMP_RED;
      conf_cnt   <= '0;
      flash_cnt  <= '0;
      allred_cnt <= '0;
      prev_hw1   <= RED;
      prev_hw2   <= RED;
      prev_fm1   <= RED;
      prev_fm2   <= RED;
    end else begin
      prev_hw1 <= Highway_1;
      prev_hw2 <= Highway_2;
      prev_fm1 <= Farm_1;
      prev_fm2 <= Farm_2;

      case (state)
        NORMAL: begin
          if (!conflict)
            conf_cnt <= '0;
          else if (conf_cnt != CONF_MAX)
            conf_cnt <= conf_cnt + 1'b1;

          if (violation) begin
            state      <= FLASH;
            fault      <= 1'b1;
            fault_code <= {trans_viol, conf_viol};
            flash_cnt  <= '0;
            hw1_lamp   <= LAMP_YELLOW;
            hw2_lamp   <= LAMP_YELLOW;
            fm1_lamp   <= LAMP_YELLOW;
            fm2_lamp   <= LAMP_YELLOW;
          end else begin
            hw1_lamp <= decode(Highway_1);
            hw2_lamp <= decode(Highway_2);
            fm1_lamp <= decode(Farm_1);
            fm2_lamp <= decode(Farm_2);
          end
        end

        FLASH: begin
          conf_cnt <= '0;
          if (fault_clr) begin
            state      <= ALL_RED;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            allred_cnt <= '0;
            hw1_lamp   <= LAMP_RED;
            hw2_lamp   <= LAMP_RED;
            fm1_lamp   <= LAMP_RED;
            fm2_lamp   <= LAMP_RED;
          end else begin
            flash_cnt <= flash_next;
            hw1_lamp  <= (flash_next < FLASH_ON) ? LAMP_YELLOW : LAMP_OFF;
            hw2_lamp  <= (flash_next < FLASH_ON) ? LAMP_YELLOW : LAMP_OFF;
            fm1_lamp  <= (flash_next < FLASH_ON) ? LAMP_YELLOW : LAMP_OFF;
            fm2_lamp  <= (flash_next < FLASH_ON) ? LAMP_YELLOW : LAMP_OFF;
          end
        end

        default: begin
          // Conflict history restarts from zero when NORMAL resumes.
          conf_cnt <= '0;
          if (allred_cnt == ALLRED_END) begin
            state    <= NORMAL;
            hw1_lamp <= decode(Highway_1);
            hw2_lamp <= decode(Highway_2);
            fm1_lamp <= decode(Farm_1);
            fm2_lamp <= decode(Farm_2);
          end else begin
            allred_cnt <= allred_cnt + 1'b1;
            hw1_lamp   <= LAMP_RED;
            hw2_lamp   <= LAMP_RED;
            fm1_lamp   <= LAMP_RED;
            fm2_lamp   <= LAMP_RED;
          end
        end
      endcase
    end
  end

endmodule
